pi_bus_initiator: RTL and testbench
===================================

# pi_bus_initiator

Bus-master end of the N64 parallel-interface (PI) cartridge protocol that the cartridge-side responder decodes. It accepts burst commands from an internal client and generates the multiplexed cartridge bus: ALEH/ALEL address phases, READ/WRITE strobes and AD data. Its uses are cartridge dumping on the dev board and closed-loop benches against the responder. It handles bursts of 1–256 halfwords, and the target auto-increments the address.

## Interface
- T_ALE, 4: cycles for each address half (high, then low); ≥1.
- T_SETUP, 8: cycles from ALEL fall to the first strobe; ≥1.
- T_PULSE, 6: strobe-low cycles per halfword; ≥2.
- T_GAP, 4: strobe-high cycles after each halfword; ≥2.
- clk  in  1  system clock.
- cold_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when IDLE; a command is accepted on the cycle where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  PI byte address; bit 0 is ignored and forced to 0.
- cmd_len  in  8  halfword count minus 1 (0..255 → 1..256).
- wr_data  in  16  write halfword.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  wr_data is consumed when wr_valid && wr_ready.
- rd_data  out  16  read halfword.
- rd_valid  out  1  single-cycle pulse; there is no backpressure.
- done  out  1  single-cycle pulse at burst completion.
- busy  out  1  high whenever the state is not IDLE.
- ad_out  out  16  AD bus drive value.
- ad_oe  out  16… no: ad_oe  out  1  AD output enable.
- ad_in  in  16  AD bus sampled value.
- aleh  out  1  address latch enable, high half.
- alel  out  1  address latch enable, low half.
- read  out  1  active-low read strobe.
- write  out  1  active-low write strobe.

## Operation
- All outputs are registered.
- Reset values:
  - aleh = 0, alel = 0, read = 1, write = 1.
  - ad_oe = 0, ad_out = 0.
  - cmd_ready = 1, wr_ready = 0, rd_valid = 0, done = 0, busy = 0.
  - rd_data = 0, state = IDLE.
- States: IDLE → ALE_HI → ALE_LO → SETUP → STROBE ↔ GAP → IDLE.
- On accept, latch the address, direction and length. Load the halfword counter with cmd_len and the timer with 0.
- ALE_HI (T_ALE cycles): aleh = 1, alel = 1, ad_oe = 1, ad_out = addr[31:16].
- ALE_LO (T_ALE cycles): aleh = 0, alel = 1, ad_out = {addr[15:1], 1'b0}.
- SETUP (T_SETUP cycles): alel = 0.
  - Read burst: ad_oe = 0 for the rest of the burst.
  - Write burst: ad_oe stays 1.
- STROBE (T_PULSE cycles): read = 0 (read burst) or write = 0 (write burst).
- GAP (T_GAP cycles): strobe high.
  - Counter nonzero: decrement it and return to STROBE.
  - Counter zero: go to IDLE.
- Write data fetch:
  - wr_ready = wr_valid in the first cycle of each SETUP or GAP that precedes a STROBE. ad_out loads wr_data on that handshake.
  - If wr_valid is low, the timer freezes at 0 and the strobe stays high. This stretches the phase until wr_valid rises; the handshake occurs in that cycle.
  - Data is therefore stable ≥ T_GAP−1 cycles before the strobe falls and is held through the following GAP.
  - wr_ready is never asserted in the final GAP.
- Read capture: ad_in is registered into rd_data at the edge ending the last STROBE cycle. rd_valid = 1 for the next cycle only.
- Completion: the IDLE entry cycle has done = 1, cmd_ready = 1 and busy = 0. A new command is accepted in that same cycle.
- Counter is 8 bits; timer is 8 bits. No address arithmetic is performed; the target increments.
- cmd_valid while busy is ignored (cmd_ready = 0). cmd_* inputs are only sampled on accept.
- cold_reset mid-burst: on the next edge all outputs return to reset values and the state returns to IDLE.
  - Any partial halfword is dropped.
  - No done or rd_valid pulse is produced.

## Timing
- The accept cycle is numbered 0.
- Phase windows:
  - ALE_HI: cycles 1..T_ALE.
  - ALE_LO: T_ALE+1..2T_ALE.
  - SETUP: next T_SETUP cycles.
  - Each halfword: T_PULSE strobe-low cycles followed by T_GAP high cycles.
- done occurs in cycle 2·T_ALE + T_SETUP + n·(T_PULSE+T_GAP) + 1, plus any write stall cycles.
- Defaults: n=1 → done at cycle 27; n=2 → done at cycle 37.
- For halfword k (0-based), rd_valid occurs in cycle 17 + 10k + 6 (defaults).
- aleh and alel never change in the same cycle as a strobe. No strobe falls while alel = 1.

## Test plan
- Read burst, defaults: cmd_addr=0x10000040, cmd_len=0; bench drives ad_in=0x8037 during the strobe.
  - aleh/alel = 1/1 with ad_out=0x1000 in cycles 1–4, then 0/1 with ad_out=0x0040 in cycles 5–8.
  - read low in cycles 17–22; rd_data=0x8037 with rd_valid in cycle 23; done in cycle 27.
- Write burst: cmd_addr=0x10400400, cmd_len=1, wr_data 0x0011 then 0x001E, wr_valid held high.
  - write low in cycles 17–22 and 27–32; ad_out matches each word at its strobe; done in cycle 37.
- Write stall: as the write burst above, but wr_valid drops for 5 cycles before the second word.
  - The second strobe is delayed by exactly 5 cycles; write stays high during the stall; done in cycle 42.
- Max burst: cmd_len=255 read.
  - Exactly 256 rd_valid pulses and 256 read falling edges; no address phase between them; done once.
- Reset mid-burst: cold_reset asserted in cycle 19 of a read.
  - From the next cycle read=1, ad_oe=0, aleh=alel=0, cmd_ready=1; no rd_valid or done.
- Back-to-back: cmd_valid held high with two commands queued.
  - The second command is accepted in the done cycle of the first; its ALE_HI begins in the following cycle.

Source files
------------

// File: rtl/pi_bus_initiator_if.sv
// ---------------------------------------------------------------------------
// pi_bus_initiator_if
//   Bundles the client command/data handshakes and the multiplexed cartridge
//   bus of the PI initiator.
//
//   Client side : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len,
//                 wr_data/wr_valid/wr_ready, rd_data/rd_valid, done, busy
//   Cartridge   : ad_out/ad_oe/ad_in (shared AD bus), aleh/alel (address
//                 latch enables), read/write (active-low strobes)
//
//   master : the initiator (drives the cartridge bus, answers the client)
//   slave  : the client/cartridge model on the other side
// ---------------------------------------------------------------------------
interface pi_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;

    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    logic [15:0] rd_data;
    logic        rd_valid;

    logic        done;
    logic        busy;

    logic [15:0] ad_out;
    logic        ad_oe;
    logic [15:0] ad_in;
    logic        aleh;
    logic        alel;
    logic        read;
    logic        write;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_valid,
        input  ad_in,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
        output ad_out, ad_oe, aleh, alel, read, write
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_valid,
        output ad_in,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
        input  ad_out, ad_oe, aleh, alel, read, write
    );
endinterface

// File: rtl/pi_bus_initiator.sv
// ---------------------------------------------------------------------------
// pi_bus_initiator
//   Bus-master end of the N64 PI cartridge protocol. Takes a burst command
//   (1..256 halfwords) from a client and sequences ALEH/ALEL address phases,
//   a setup delay, then READ/WRITE strobe pulses separated by gaps. The
//   target auto-increments the address, so no address arithmetic is done.
//
//   Ports
//     clk         system clock
//     cold_reset  synchronous active-high reset
//     bus         pi_bus_initiator_if.master (client handshakes + AD bus)
//
//   Parameters (cycles)
//     T_ALE    each address half (>=1)
//     T_SETUP  ALEL fall to first strobe (>=1)
//     T_PULSE  strobe low per halfword (>=2)
//     T_GAP    strobe high after each halfword (>=2)
//
//   State table
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     IDLE     | waiting for a command, cmd_ready high
//     ALE_HI   | aleh=alel=1, AD drives addr[31:16]
//     ALE_LO   | alel=1, AD drives addr[15:0] (bit 0 forced low)
//     SETUP    | address latched by target; write burst fetches word 0
//     STROBE   | read or write strobe low
//     GAP      | strobe high; write burst fetches the next word
//
//   Every output is a flop: next-cycle values are computed from the next
//   state and registered together.
// ---------------------------------------------------------------------------
module pi_bus_initiator #(
    parameter int T_ALE   = 4,
    parameter int T_SETUP = 8,
    parameter int T_PULSE = 6,
    parameter int T_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  cold_reset,
    pi_bus_initiator_if.master    bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALE_HI = 3'd1;
    localparam logic [2:0] S_ALE_LO = 3'd2;
    localparam logic [2:0] S_SETUP  = 3'd3;
    localparam logic [2:0] S_STROBE = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    // Timer counts up from 0; a phase ends when it reaches its last value.
    localparam logic [7:0] ALE_LAST   = 8'(T_ALE - 1);
    localparam logic [7:0] SETUP_LAST = 8'(T_SETUP - 1);
    localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 1);
    localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 1);

    // Sequencing state
    logic [2:0]  state_q,  state_d;
    logic [7:0]  timer_q,  timer_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [31:0] addr_q,   addr_d;
    logic        dir_wr_q, dir_wr_d;

    // Registered outputs
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_ready_q,  wr_ready_d;
    logic [15:0] rd_data_q,   rd_data_d;
    logic        rd_valid_q,  rd_valid_d;
    logic        done_q,      done_d;
    logic        busy_q,      busy_d;
    logic [15:0] ad_out_q,    ad_out_d;
    logic        ad_oe_q,     ad_oe_d;
    logic        aleh_q,      aleh_d;
    logic        alel_q,      alel_d;
    logic        read_q,      read_d;
    logic        write_q,     write_d;

    // Write-data fetch: wr_ready is held high from the first cycle of the
    // fetching phase until the handshake. While it is high and wr_valid is
    // low the phase is frozen (timer stays at 0, strobe stays high).
    logic wr_stall;
    logic wr_take;
    logic strobe_d;

    assign wr_stall = wr_ready_q && !bus.wr_valid;
    assign wr_take  = wr_ready_q &&  bus.wr_valid;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dir_wr_d   = dir_wr_q;
        ad_out_d   = ad_out_q;
        rd_data_d  = rd_data_q;
        wr_ready_d = wr_ready_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d  = S_ALE_HI;
                    timer_d  = 8'd0;
                    cnt_d    = bus.cmd_len;
                    addr_d   = bus.cmd_addr & 32'hFFFF_FFFE;
                    dir_wr_d = bus.cmd_write;
                    ad_out_d = addr_d[31:16];
                end
            end

            S_ALE_HI: begin
                if (timer_q == ALE_LAST) begin
                    state_d  = S_ALE_LO;
                    timer_d  = 8'd0;
                    ad_out_d = addr_q[15:0];
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_ALE_LO: begin
                if (timer_q == ALE_LAST) begin
                    state_d    = S_SETUP;
                    timer_d    = 8'd0;
                    wr_ready_d = dir_wr_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_SETUP: begin
                if (!wr_stall) begin
                    if (wr_take) begin
                        ad_out_d   = bus.wr_data;
                        wr_ready_d = 1'b0;
                    end
                    if (timer_q == SETUP_LAST) begin
                        state_d = S_STROBE;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end

            S_STROBE: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = S_GAP;
                    timer_d = 8'd0;
                    // Sample AD at the edge that ends the strobe.
                    if (!dir_wr_q) begin
                        rd_data_d  = bus.ad_in;
                        rd_valid_d = 1'b1;
                    end
                    // Only a gap that leads to another strobe fetches data.
                    wr_ready_d = dir_wr_q && (cnt_q != 8'd0);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            S_GAP: begin
                if (!wr_stall) begin
                    if (wr_take) begin
                        ad_out_d   = bus.wr_data;
                        wr_ready_d = 1'b0;
                    end
                    if (timer_q == GAP_LAST) begin
                        timer_d = 8'd0;
                        if (cnt_q != 8'd0) begin
                            cnt_d   = cnt_q - 8'd1;
                            state_d = S_STROBE;
                        end else begin
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                            ad_out_d = 16'h0000;
                        end
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                timer_d    = 8'd0;
                wr_ready_d = 1'b0;
                ad_out_d   = 16'h0000;
            end
        endcase

        // Bus-level outputs follow directly from where the FSM goes next.
        strobe_d    = (state_d == S_STROBE);
        aleh_d      = (state_d == S_ALE_HI);
        alel_d      = (state_d == S_ALE_HI) || (state_d == S_ALE_LO);
        read_d      = !(strobe_d && !dir_wr_d);
        write_d     = !(strobe_d &&  dir_wr_d);
        // Reads release AD once the address is latched; writes keep driving.
        ad_oe_d     = alel_d ||
                      (dir_wr_d && ((state_d == S_SETUP) ||
                                    (state_d == S_STROBE) ||
                                    (state_d == S_GAP)));
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (cold_reset) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            dir_wr_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= 16'h0000;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ad_out_q    <= 16'h0000;
            ad_oe_q     <= 1'b0;
            aleh_q      <= 1'b0;
            alel_q      <= 1'b0;
            read_q      <= 1'b1;
            write_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dir_wr_q    <= dir_wr_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ad_out_q    <= ad_out_d;
            ad_oe_q     <= ad_oe_d;
            aleh_q      <= aleh_d;
            alel_q      <= alel_d;
            read_q      <= read_d;
            write_q     <= write_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.ad_out    = ad_out_q;
    assign bus.ad_oe     = ad_oe_q;
    assign bus.aleh      = aleh_q;
    assign bus.alel      = alel_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;

endmodule

// File: tb/tb_pi_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_pi_bus_initiator
//   Drives bursts cycle by cycle. For every burst the expected timeline is
//   computed up front from the protocol timing (phase lengths, per-word
//   write stalls), then each cycle's outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_pi_bus_initiator;

    localparam int A = 4;
    localparam int S = 8;
    localparam int P = 6;
    localparam int G = 4;

    logic clk = 1'b0;
    logic cold_reset = 1'b1;

    always #5 clk = ~clk;

    pi_bus_initiator_if bus ();

    pi_bus_initiator #(
        .T_ALE   (A),
        .T_SETUP (S),
        .T_PULSE (P),
        .T_GAP   (G)
    ) dut (
        .clk        (clk),
        .cold_reset (cold_reset),
        .bus        (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Per-burst model data
    int          st      [256];   // cycle of strobe fall for word k
    int          fetch_c [256];   // first cycle of the phase fetching word k
    int          stall_c [256];   // wr_valid-low cycles at that fetch
    logic [15:0] words   [256];
    logic [15:0] adin_log[8192];
    bit          ad_fix;
    logic [15:0] ad_fix_val;
    bit          hold_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic prep(input int n, input int smax);
        for (int k = 0; k < n; k++) begin
            words[k]   = 16'($urandom);
            stall_c[k] = $urandom_range(0, smax);
        end
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_aleh"},      bus.aleh, 0);
        chk({pfx, "_alel"},      bus.alel, 0);
        chk({pfx, "_read"},      bus.read, 1);
        chk({pfx, "_write"},     bus.write, 1);
        chk({pfx, "_ad_oe"},     bus.ad_oe, 0);
        chk({pfx, "_ad_out"},    bus.ad_out, 0);
        chk({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({pfx, "_wr_ready"},  bus.wr_ready, 0);
        chk({pfx, "_rd_valid"},  bus.rd_valid, 0);
        chk({pfx, "_done"},      bus.done, 0);
        chk({pfx, "_busy"},      bus.busy, 0);
    endtask

    // Entered at a negedge in which the DUT is idle (that cycle becomes
    // cycle 0). Returns at the negedge of the done cycle.
    task automatic run_burst(input bit wr, input logic [31:0] addr, input int len);
        int          n, done_c, kk, sk, rk, rdv, falls, dones;
        logic        prev_read;
        logic [31:0] a;

        n = len + 1;
        a = addr & 32'hFFFF_FFFE;
        if (!wr) for (int k = 0; k < n; k++) stall_c[k] = 0;

        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                fetch_c[0] = 2 * A + 1;
                st[0]      = fetch_c[0] + stall_c[0] + S;
            end else begin
                fetch_c[k] = st[k-1] + P;
                st[k]      = fetch_c[k] + stall_c[k] + G;
            end
        end
        done_c = st[n-1] + P + G;

        chk("cmd_ready_at_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 8'(len);
        bus.wr_valid  = 1'b1;
        bus.wr_data   = words[0];
        bus.ad_in     = ad_fix ? ad_fix_val : 16'($urandom);
        adin_log[0]   = bus.ad_in;

        kk = 0; rdv = 0; falls = 0; dones = 0; prev_read = 1'b1;
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Junk on the command port while busy must be ignored.
                bus.cmd_valid = hold_valid;
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = $urandom;
                bus.cmd_len   = 8'($urandom);
            end
            while (kk + 1 < n && fetch_c[kk+1] <= c) kk++;
            sk = -1; rk = -1;
            for (int k = 0; k < n; k++) begin
                if (c >= st[k] && c < st[k] + P) sk = k;
                if (c == st[k] + P) rk = k;
            end

            chk("aleh",      bus.aleh, c <= A);
            chk("alel",      bus.alel, c <= 2 * A);
            chk("read",      bus.read, !(sk >= 0 && !wr));
            chk("write",     bus.write, !(sk >= 0 && wr));
            chk("ad_oe",     bus.ad_oe, (c <= 2 * A) || (wr && c < done_c));
            chk("busy",      bus.busy, c < done_c);
            chk("cmd_ready", bus.cmd_ready, c == done_c);
            chk("done",      bus.done, c == done_c);
            chk("rd_valid",  bus.rd_valid, !wr && rk >= 0);
            if (!wr && rk >= 0) chk("rd_data", bus.rd_data, adin_log[st[rk] + P - 1]);
            chk("wr_ready",  bus.wr_ready,
                wr && c >= fetch_c[kk] && c <= fetch_c[kk] + stall_c[kk]);
            if (c <= A)          chk("ad_addr_hi", bus.ad_out, a[31:16]);
            else if (c <= 2 * A) chk("ad_addr_lo", bus.ad_out, a[15:0]);
            if (wr && sk >= 0)   chk("ad_wdata", bus.ad_out, words[sk]);

            if (prev_read && !bus.read) falls++;
            prev_read = bus.read;
            if (bus.rd_valid) rdv++;
            if (bus.done) dones++;

            bus.wr_valid = !(c >= fetch_c[kk] && c < fetch_c[kk] + stall_c[kk]);
            bus.wr_data  = words[kk];
            bus.ad_in    = ad_fix ? ad_fix_val : 16'($urandom);
            adin_log[c]  = bus.ad_in;
        end
        bus.cmd_valid = 1'b0;
        chk("n_rd_valid",   rdv, wr ? 0 : n);
        chk("n_read_falls", falls, wr ? 0 : n);
        chk("n_done",       dones, 1);
    endtask

    initial begin
        int          len;
        bit          wr, chain;
        logic [31:0] addr;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_len   = 8'd0;
        bus.wr_data   = 16'h0000;
        bus.wr_valid  = 1'b0;
        bus.ad_in     = 16'h0000;
        ad_fix        = 1'b0;
        ad_fix_val    = 16'h0000;
        hold_valid    = 1'b0;

        cold_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        chk("por_rd_data", bus.rd_data, 0);
        cold_reset = 1'b0;
        @(negedge clk);

        // Directed read, defaults
        ad_fix = 1'b1; ad_fix_val = 16'h8037;
        run_burst(1'b0, 32'h1000_0040, 0);
        ad_fix = 1'b0;
        chk("rd_data_hold", bus.rd_data, 16'h8037);
        repeat (2) @(negedge clk);

        // Directed write, two words, no stall
        prep(2, 0);
        words[0] = 16'h0011; words[1] = 16'h001E;
        run_burst(1'b1, 32'h1040_0400, 1);
        repeat (2) @(negedge clk);

        // Same write, 5-cycle stall before the second word
        prep(2, 0);
        words[0] = 16'h0011; words[1] = 16'h001E; stall_c[1] = 5;
        run_burst(1'b1, 32'h1040_0400, 1);
        repeat (2) @(negedge clk);

        // Maximum read burst
        run_burst(1'b0, $urandom, 255);
        repeat (2) @(negedge clk);

        // Back-to-back with cmd_valid held high through the first burst
        hold_valid = 1'b1;
        run_burst(1'b0, $urandom, 2);
        hold_valid = 1'b0;
        prep(2, 2);
        run_burst(1'b1, $urandom, 1);
        repeat (2) @(negedge clk);

        // Randomized bursts, some chained
        for (int i = 0; i < 14; i++) begin
            wr    = 1'($urandom);
            len   = $urandom_range(0, 12);
            addr  = $urandom;
            chain = 1'($urandom);
            prep(len + 1, 3);
            hold_valid = chain;
            run_burst(wr, addr, len);
            hold_valid = 1'b0;
            if (!chain) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("idle_busy", bus.busy, 0);
                end
            end
        end
        repeat (2) @(negedge clk);

        // Reset in cycle 19 of a read burst
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h1000_0000;
        bus.cmd_len   = 8'd3;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.ad_in     = 16'($urandom);
        end
        chk("pre_rst_read_low", bus.read, 0);
        cold_reset = 1'b1;
        @(negedge clk);
        chk_reset_values("midrst");
        cold_reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("post_rst_rd_valid", bus.rd_valid, 0);
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_busy", bus.busy, 0);
        end

        // Still operational after the abort
        prep(3, 2);
        run_burst(1'b1, $urandom, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
